// File: rtl/text_buffer.sv
// text_buffer: character-cell text buffer with cursor, newline/backspace handling and a registered read port.
// Optional TEXT_BUFFER_CURSOR_EN overlays an underscore at the cursor while cursor_blink is high.
module text_buffer #(
  parameter int COLS = 70,
  parameter int ROWS = 30
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       in_valid,
  input  logic [7:0] in_ascii,
  output logic       in_ready,
  input  logic [4:0] rd_row,
  input  logic [6:0] rd_col,
  output logic [7:0] rd_data,
  input  logic       cursor_blink,
  output logic [4:0] cur_row,
  output logic [6:0] cur_col
);
  typedef enum logic [1:0] {CLEAR_ALL, IDLE, CLEAR_ROW} state_t;
  state_t state_q, state_d;
  logic [4:0] row_q, row_d, clr_row_q, clr_row_d, row_inc;
  logic [6:0] col_q, col_d, clr_col_q, clr_col_d;
  logic in_ready_q, in_ready_d;
  logic we, last_col, last_row, eol, printable, newline;
  logic [11:0] wa;
  logic [7:0] wd, ram_q;
  logic [7:0] mem [4096];
  assign last_col = clr_col_q == 7'(COLS - 1);
  assign last_row = clr_row_q == 5'(ROWS - 1);
  assign eol = col_q == 7'(COLS - 1);
  assign row_inc = row_q == 5'(ROWS - 1) ? 5'd0 : row_q + 5'd1;
  assign printable = in_ascii >= 8'h20 && in_ascii <= 8'h7E;
  assign newline = in_ascii == 8'h0A || in_ascii == 8'h0D;
  always_comb begin
    state_d = state_q;
    row_d = row_q;
    col_d = col_q;
    clr_row_d = clr_row_q;
    clr_col_d = clr_col_q;
    we = 1'b0;
    wa = {row_q, col_q};
    wd = 8'h20;
    case (state_q)
      CLEAR_ALL: begin
        we = 1'b1;
        wa = {clr_row_q, clr_col_q};
        clr_col_d = last_col ? 7'd0 : clr_col_q + 7'd1;
        clr_row_d = last_col ? (last_row ? 5'd0 : clr_row_q + 5'd1) : clr_row_q;
        state_d = last_col && last_row ? IDLE : CLEAR_ALL;
      end
      CLEAR_ROW: begin
        we = 1'b1;
        wa = {row_q, clr_col_q};
        clr_col_d = last_col ? 7'd0 : clr_col_q + 7'd1;
        state_d = last_col ? IDLE : CLEAR_ROW;
      end
      default: if (in_valid && in_ready_q) begin
        if (printable) begin
          we = 1'b1;
          wd = in_ascii;
          col_d = eol ? 7'd0 : col_q + 7'd1;
          row_d = eol ? row_inc : row_q;
          state_d = eol ? CLEAR_ROW : IDLE;
        end else if (newline) begin
          col_d = 7'd0;
          row_d = row_inc;
          state_d = CLEAR_ROW;
        end else if (in_ascii == 8'h08 && col_q != 7'd0) begin
          col_d = col_q - 7'd1;
          we = 1'b1;
          wa = {row_q, col_q - 7'd1};
        end
      end
    endcase
    in_ready_d = state_d == IDLE;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= CLEAR_ALL;
      row_q <= '0;
      col_q <= '0;
      clr_row_q <= '0;
      clr_col_q <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q <= row_d;
      col_q <= col_d;
      clr_row_q <= clr_row_d;
      clr_col_q <= clr_col_d;
      in_ready_q <= in_ready_d;
    end
  end
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) ram_q <= 8'h00;
    else ram_q <= mem[{rd_row, rd_col}];
  end
  assign in_ready = in_ready_q;
  assign cur_row = row_q;
  assign cur_col = col_q;
`ifdef TEXT_BUFFER_CURSOR_EN
  logic [11:0] ra_q;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) ra_q <= '0;
    else ra_q <= {rd_row, rd_col};
  end
  assign rd_data = cursor_blink && ra_q == {row_q, col_q} ? 8'h5F : ram_q;
`else
  logic unused_blink;
  assign unused_blink = cursor_blink;
  assign rd_data = ram_q;
`endif
endmodule

// File: tb/tb_text_buffer.sv
// tb_text_buffer: screen/cursor model checked every cycle, plus directed literal checks.
module tb_text_buffer;
  localparam int COLS = 70, ROWS = 30, CELLS = COLS * ROWS;
  logic clk = 0, resetn = 0, in_valid = 0, cursor_blink = 0;
  logic [7:0] in_ascii = 0;
  logic [4:0] rd_row = 0;
  logic [6:0] rd_col = 0;
  logic in_ready;
  logic [7:0] rd_data;
  logic [4:0] cur_row;
  logic [6:0] cur_col;
  int passes = 0, total = 0;
  text_buffer dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ascii(in_ascii), .in_ready(in_ready),
    .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data), .cursor_blink(cursor_blink),
    .cur_row(cur_row), .cur_col(cur_col)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
  endtask
  // model: screen contents, cursor, and cycles left in any blanking sweep
  logic [7:0] scr [CELLS];
  bit known [CELLS];
  int all_left = 0, row_left = 0, m_row = 0, m_col = 0, ra_r = 0, ra_c = 0, a;
  bit m_ready = 0, rd_known = 0, acc;
  logic [7:0] rd_exp = 0;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      all_left = CELLS; row_left = 0; m_row = 0; m_col = 0; m_ready = 0;
      rd_exp = 0; rd_known = 1; ra_r = 0; ra_c = 0;
    end else begin
      acc = in_valid && m_ready;
      a = rd_row * COLS + rd_col;
      rd_exp = scr[a]; rd_known = known[a]; ra_r = rd_row; ra_c = rd_col;
      if (all_left > 0) begin
        scr[CELLS - all_left] = 8'h20; known[CELLS - all_left] = 1; all_left--;
      end else if (row_left > 0) begin
        scr[m_row * COLS + COLS - row_left] = 8'h20; known[m_row * COLS + COLS - row_left] = 1; row_left--;
      end else if (acc) begin
        if (in_ascii >= 8'h20 && in_ascii <= 8'h7E) begin
          scr[m_row * COLS + m_col] = in_ascii; known[m_row * COLS + m_col] = 1;
          if (m_col < COLS - 1) m_col++;
          else begin m_col = 0; m_row = (m_row + 1) % ROWS; row_left = COLS; end
        end else if (in_ascii == 8'h0A || in_ascii == 8'h0D) begin
          m_col = 0; m_row = (m_row + 1) % ROWS; row_left = COLS;
        end else if (in_ascii == 8'h08 && m_col > 0) begin
          m_col--; scr[m_row * COLS + m_col] = 8'h20;
        end
      end
      m_ready = all_left == 0 && row_left == 0;
    end
  end
  always @(negedge clk) begin
    logic [7:0] e;
    chk("in_ready", in_ready, m_ready);
    chk("cur_row", cur_row, m_row);
    chk("cur_col", cur_col, m_col);
    e = rd_exp;
`ifdef TEXT_BUFFER_CURSOR_EN
    if (cursor_blink && ra_r == m_row && ra_c == m_col) e = 8'h5F;
`endif
    if (rd_known) chk("rd_data", rd_data, e);
  end
  task automatic step;
    @(posedge clk); #2;
  endtask
  task automatic wait_ready(output int n);
    n = 0;
    while (!in_ready && n < 5000) begin step; n++; end
  endtask
  task automatic send(input logic [7:0] ch);
    int n;
    wait_ready(n);
    if (!in_ready) chk("send_timeout", 0, 1);
    in_valid = 1; in_ascii = ch;
    step;
    in_valid = 0;
  endtask
  task automatic read_cell(input int r, input int c, output logic [7:0] d);
    rd_row = 5'(r); rd_col = 7'(c);
    step;
    d = rd_data;
  endtask
  task automatic count_nonspace(input int r0, input int r1, output int bad);
    logic [7:0] d;
    bad = 0;
    for (int r = r0; r <= r1; r++)
      for (int c = 0; c < COLS; c++) begin
        read_cell(r, c, d);
        if (d != 8'h20) bad++;
      end
  endtask
  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
  initial begin
    int n, bad;
    logic [7:0] d;
    resetn = 0;
    repeat (3) step;
    chk("reset_ready", in_ready, 0);
    chk("reset_rd_data", rd_data, 8'h00);
    resetn = 1;
    wait_ready(n);
    chk("clear_all_len", n, 2100);
    chk("reset_row", cur_row, 0);
    chk("reset_col", cur_col, 0);
    count_nonspace(0, ROWS - 1, bad);
    chk("clear_all_cells", bad, 0);
    send(8'h41);
    send(8'h42);
    chk("ab_col", cur_col, 2);
    read_cell(0, 0, d); chk("cell_0_0", d, 8'h41);
    read_cell(0, 1, d); chk("cell_0_1", d, 8'h42);
    send(8'h0D);
    chk("nl_row", cur_row, 1);
    chk("nl_col", cur_col, 0);
    wait_ready(n);
    chk("clear_row_len", n, 70);
    send(8'h08);
    chk("bs0_col", cur_col, 0);
    chk("bs0_row", cur_row, 1);
    send(8'h43);
    read_cell(1, 0, d); chk("cell_1_0_C", d, 8'h43);
    send(8'h08);
    chk("bs_col", cur_col, 0);
    read_cell(1, 0, d); chk("cell_1_0_bs", d, 8'h20);
    repeat (28) send(8'h0A);
    wait_ready(n);
    chk("row29", cur_row, 29);
    for (int i = 0; i < COLS; i++) send(8'h61 + 8'(i % 26));
    chk("wrap_row", cur_row, 0);
    chk("wrap_col", cur_col, 0);
    wait_ready(n);
    chk("wrap_clear_len", n, 70);
    count_nonspace(0, 0, bad);
    chk("row0_blank", bad, 0);
    read_cell(29, 0, d); chk("cell_29_0", d, 8'h61);
    read_cell(29, 69, d); chk("cell_29_69", d, 8'h72);
    send(8'h07);
    chk("bel_ready", in_ready, 1);
    chk("bel_col", cur_col, 0);
    send(8'h0A);
    send(8'h0A);
    repeat (5) send(8'h78);
    chk("cur_2_5_row", cur_row, 2);
    chk("cur_2_5_col", cur_col, 5);
    cursor_blink = 1;
    read_cell(2, 5, d);
`ifdef TEXT_BUFFER_CURSOR_EN
    chk("overlay_on", d, 8'h5F);
`else
    chk("overlay_on", d, 8'h20);
`endif
    cursor_blink = 0;
    read_cell(2, 5, d); chk("overlay_off", d, 8'h20);
    send(8'h0A);
    repeat (34) step;
    chk("mid_clear_busy", in_ready, 0);
    resetn = 0;
    step;
    resetn = 1;
    wait_ready(n);
    chk("mid_reset_clear_len", n, 2100);
    chk("mid_reset_row", cur_row, 0);
    chk("mid_reset_col", cur_col, 0);
    step;
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
